// File: rtl/sound_event_scheduler_pkg.sv
// Shared constants, state type and priority helpers for the sound event scheduler.
// Sound index == bit position in play_sel; a lower index means higher priority.
package sound_pkg;

  localparam int GAMEOVER = 0;
  localparam int WIN      = 1;
  localparam int COIN     = 2;
  localparam int NUM_SOUNDS = 3;

  // Highest to lowest priority.
  localparam int PRIO_ORDER [NUM_SOUNDS] = '{GAMEOVER, WIN, COIN};

  localparam int LEN_COIN_DEF     = 10095;
  localparam int LEN_WIN_DEF      = 50796;
  localparam int LEN_GAMEOVER_DEF = 17197;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  // One-hot of the highest-priority set bit (lowest index).
  function automatic logic [NUM_SOUNDS-1:0] highest_pending(input logic [NUM_SOUNDS-1:0] p);
    return p & (~p + 3'd1);
  endfunction

  // Sounds whose priority is equal to or higher than the one-hot cur.
  function automatic logic [NUM_SOUNDS-1:0] at_or_above(input logic [NUM_SOUNDS-1:0] cur);
    return cur | (cur - 3'd1);
  endfunction

endpackage

// File: rtl/sound_event_scheduler_if.sv
// Request/playback bus between game logic (master) and the sound scheduler (slave).
interface sound_event_scheduler_if #(
  parameter int ADDR_W = 18
);
  logic              ev_coin;
  logic              ev_win;
  logic              ev_gameover;
  logic              stop;
  logic [2:0]        play_sel;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rden;
  logic              busy;
  logic              done;

  modport master (
    output ev_coin, ev_win, ev_gameover, stop,
    input  play_sel, rom_addr, rom_rden, busy, done
  );

  modport slave (
    input  ev_coin, ev_win, ev_gameover, stop,
    output play_sel, rom_addr, rom_rden, busy, done
  );
endinterface

// File: rtl/sound_event_scheduler_lrclk_tick_sync.sv
// Brings the DAC LR clock into the clk domain and emits a 1-clk sample_tick
// three clocks after each LR rising edge.
module lrclk_tick_sync (
  input  logic clk,
  input  logic reset,
  input  logic dac_lr_clk,
  output logic sample_tick
);

  logic lr_p0, lr_p1, lr_p2;
  logic tick_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lr_p0  <= 1'b0;
      lr_p1  <= 1'b0;
      lr_p2  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      // p0/p1: metastability filter; p2: previous level for edge detect
      lr_p0  <= dac_lr_clk;
      lr_p1  <= lr_p0;
      lr_p2  <= lr_p1;
      tick_q <= lr_p1 & ~lr_p2;
    end
  end

  assign sample_tick = tick_q;

endmodule

// File: rtl/sound_event_scheduler.sv
// Fixed-priority, preempting sound clip scheduler driving ROM addresses for the DAC path.
// Build option: define SOUND_QUEUE_EN to queue lower-priority requests that arrive during playback.
module sound_event_scheduler
  import sound_pkg::*;
#(
  parameter int LEN_COIN     = LEN_COIN_DEF,
  parameter int LEN_WIN      = LEN_WIN_DEF,
  parameter int LEN_GAMEOVER = LEN_GAMEOVER_DEF,
  parameter int ADDR_W       = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic codec_ready,
  input  logic dac_lr_clk,
  sound_event_scheduler_if.slave bus
);

`ifdef SOUND_QUEUE_EN
  localparam bit QUEUE_EN = 1'b1;
`else
  localparam bit QUEUE_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_COIN     = ADDR_W'(LEN_COIN - 1);
  localparam logic [ADDR_W-1:0] LAST_WIN      = ADDR_W'(LEN_WIN - 1);
  localparam logic [ADDR_W-1:0] LAST_GAMEOVER = ADDR_W'(LEN_GAMEOVER - 1);

  logic sample_tick;

  lrclk_tick_sync u_tick (
    .clk         (clk),
    .reset       (reset),
    .dac_lr_clk  (dac_lr_clk),
    .sample_tick (sample_tick)
  );

  state_t                  state_q, state_d;
  logic [NUM_SOUNDS-1:0]   cur_q, cur_d;
  logic [NUM_SOUNDS-1:0]   pend_q, pend_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    done_q, done_d;
  logic [NUM_SOUNDS-1:0]   ev;
  logic [NUM_SOUNDS-1:0]   sel;
  logic [ADDR_W-1:0]       last_addr;

  assign ev = {bus.ev_coin, bus.ev_win, bus.ev_gameover};

  always_comb begin
    last_addr = LAST_GAMEOVER;
    if (cur_q[COIN])     last_addr = LAST_COIN;
    else if (cur_q[WIN]) last_addr = LAST_WIN;
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    pend_d  = pend_q | ev;
    sel     = '0;

    case (state_q)
      S_INIT: begin
        if (codec_ready) state_d = S_IDLE;
      end

      S_IDLE: begin
        sel = highest_pending(pend_q);
        if (|sel) begin
          cur_d   = sel;
          pend_d  = (pend_q & ~sel) | ev;
          addr_d  = '0;
          state_d = S_PLAY;
        end
      end

      S_PLAY: begin
        // Same or higher priority pending request restarts/preempts from address 0
        sel = highest_pending(pend_q & at_or_above(cur_q));
        if (|sel) begin
          cur_d  = sel;
          pend_d = (pend_q & ~sel) | ev;
          addr_d = '0;
        end else if (sample_tick) begin
          if (addr_q == last_addr) begin
            done_d  = 1'b1;
            state_d = S_GAP;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
        if (!QUEUE_EN) pend_d = pend_d & at_or_above(cur_d);
      end

      S_GAP: begin
        if (sample_tick) state_d = S_IDLE;
      end

      default: state_d = S_INIT;
    endcase

    if (bus.stop) begin
      pend_d  = '0;
      addr_d  = '0;
      done_d  = 1'b0;
      state_d = (state_q == S_INIT) ? S_INIT : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      cur_q   <= '0;
      pend_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign bus.play_sel = (state_q == S_PLAY) ? cur_q : 3'b000;
  assign bus.rom_addr = addr_q;
  assign bus.rom_rden = |bus.play_sel;
  assign bus.busy     = (state_q == S_PLAY) || (state_q == S_GAP);
  assign bus.done     = done_q;

endmodule

// File: doc/sound_event_scheduler.md
# sound_event_scheduler

Arbitrates game sound requests (coin, win, gameover) onto the single shared WM8731 DAC playback path and sequences the sample ROM addresses for the selected clip. It sits between game logic and the sound ROMs / DAC serializer. It waits for codec configuration to complete, then advances one ROM address per LR frame. Fixed priority with preemption applies, plus an enforced silent gap between clips.

## Interface
- `LEN_COIN`, 10095, coin clip length in samples.
- `LEN_WIN`, 50796, win clip length in samples.
- `LEN_GAMEOVER`, 17197, gameover clip length in samples.
- `ADDR_W`, 18, ROM address width; every LEN must be ≤ 2^ADDR_W.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `codec_ready`  in  1  level; codec I2C configuration finished.
- `dac_lr_clk`  in  1  raw LR clock from the BCLK domain; asynchronous to clk.
- `ev_coin`, `ev_win`, `ev_gameover`  in  1 each  request pulses, at least 1 clk wide.
- `stop`  in  1  abort playback and clear all pending requests.
- `play_sel`  out  3  one-hot {coin, win, gameover}; 0 means silence.
- `rom_addr`  out  ADDR_W  address for the selected ROM.
- `rom_rden`  out  1  equals |play_sel.
- `busy`  out  1  high in PLAY or GAP.
- `done`  out  1  1-clk pulse when a clip plays to its last sample.

## Operation
- States:
  - INIT: waits for codec_ready = 1, then goes to IDLE.
  - IDLE: if any request is pending, selects the highest-priority one (gameover > win > coin), clears its pending bit, sets rom_addr = 0, and goes to PLAY.
  - PLAY: on each sample_tick, if rom_addr == LEN(cur) − 1, pulses done and goes to GAP. Otherwise rom_addr increments.
  - GAP: play_sel = 0; on the next sample_tick goes to IDLE.
- Request latch: the pending bit for a sound is set on any clk its ev_* is high. The ev_* value is checked each clk.
- Preemption in PLAY:
  - A request with priority higher than the current clip switches to it on the next clk with rom_addr = 0. The preempted clip is discarded, not resumed.
  - A request for the same sound as the current clip restarts it at rom_addr = 0 on the next clk.
- Lower-priority requests during PLAY follow Configuration.
- Simultaneous requests: the highest priority wins. The others are handled as lower-priority requests.
- stop: next clk gives play_sel = 0, rom_addr = 0, pending = 0, and the state goes to IDLE, or stays in INIT if it was there. stop takes priority over same-cycle requests.
- codec_ready falling outside INIT has no effect.
- Address arithmetic is unsigned ADDR_W. rom_addr never exceeds LEN − 1 and never wraps.

## Timing
- Reset values: play_sel = 0, rom_addr = 0, rom_rden = 0, busy = 0, done = 0, state INIT, pending = 0. Reset mid-clip reaches these values on the next clk edge.
- sample_tick is a 1-clk pulse asserted 3 clk after the rising edge of dac_lr_clk: 2-flop synchronizer plus edge detect.
- Request latency: from IDLE with the request pulse at clk n, the pend bit sets at n+1, and play_sel and rom_addr = 0 are valid at n+2.
- Preemption and restart take effect 2 clk after the request pulse.
- rom_addr changes exactly 1 clk after sample_tick. ROM data is valid 1 clk after that, which the serializer accounts for.
- The done pulse coincides with the PLAY→GAP transition.

## Configuration
- `SOUND_QUEUE_EN` defined: lower-priority requests arriving during PLAY set their pending bit. They play after the current clip and its GAP.
- `SOUND_QUEUE_EN` undefined: pending bits of lower-priority sounds are masked while in PLAY, so those requests are dropped.
- In both builds, requests arriving in INIT, IDLE or GAP are always latched.

## Structure
- Shared package `sound_pkg` holds:
  - the sound index constants (COIN = 2, WIN = 1, GAMEOVER = 0, matching bit positions in play_sel);
  - the priority order;
  - the default clip lengths;
  - the FSM state typedef.
- One sub-module, `lrclk_tick_sync`: 2-flop synchronizer of dac_lr_clk plus rising-edge detect, producing sample_tick.

## Test plan
- Startup: request ev_coin while codec_ready = 0 → play_sel stays 0. Then raise codec_ready → play_sel = 3'b100 and rom_addr walks 0…10094 over 10095 ticks. done pulses once, and after one GAP tick busy = 0.
- Preemption: coin at rom_addr = 500, then ev_gameover → 2 clk later play_sel = 3'b001, rom_addr = 0. Coin does not resume.
- Queue: during win playback, pulse ev_coin.
  - SOUND_QUEUE_EN defined: coin starts after win's done plus 1 GAP tick.
  - Undefined: busy falls after the GAP and coin never plays.
- Simultaneous: ev_coin and ev_win on the same clk from IDLE → play_sel = 3'b010.
- Retrigger and stop: ev_coin at rom_addr = 3000 → rom_addr = 0 after 2 clk. Then stop → play_sel = 0, rom_addr = 0, no done pulse.
- Reset mid-clip: reset at gameover rom_addr = 9000 → all outputs 0 on the next clk. State returns to INIT and waits for codec_ready.
